blake_nonce_sched: RTL and testbench
====================================

# blake_nonce_sched

Work scheduler for the pipelined BLAKE-256 hashing core. It accepts a work unit (midstate, 96-bit header tail, nonce range, 32-bit target), loads it into the core and paces nonces into it. It matches each returned hash word to its nonce and queues qualifying hits in a small FIFO for the host interface. It sits between the host/UART work path and a single core instance, and owns that core's reset/load line.

## Interface
- NONCE_PERIOD, 14: cycles between successive core nonce samples.
- LOAD_CYCLES, 2: cycles `core_rst` is held high to load a work unit (≥1).
- FOUND_DEPTH, 4: found-FIFO entries (power of two, ≥2).

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- work_valid  in  1  work offer; transfer when `work_valid & work_ready`.
- work_ready  out  1  high only in IDLE.
- work_state  in  256  midstate.
- work_data  in  96  header tail words.
- work_nonce_start  in  32  first nonce.
- work_nonce_count  in  32  number of nonces to scan; 0 = empty range.
- work_target  in  32  hit when `core_hash <= work_target`, unsigned.
- abort  in  1  level; cancels the current unit.
- core_rst  out  1  active-high load/park strobe to the core.
- core_state  out  256  registered copy of `work_state`.
- core_data  out  96  registered copy of `work_data`.
- core_nonce  out  32  nonce presented to the core.
- core_hash_ready  in  1  core result strobe; results return in issue order.
- core_hash  in  32  result word, valid with `core_hash_ready`.
- found_valid / found_ready  out / in  1  found-FIFO head handshake.
- found_nonce  out  32  nonce of head hit.
- found_hash  out  32  hash word of head hit.
- busy  out  1  high in LOAD, RUN, DRAIN.
- done  out  1  one-cycle pulse when a unit completes normally.
- overflow  out  1  sticky: a hit was dropped because the FIFO was full. Cleared on next work accept.
- hashes_done  out  32  results checked for the current unit. Cleared on accept.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE: `core_rst`=1, `work_ready`=1.
  - On accept, latch all work fields and set `issued`=0, `returned`=0 (33-bit counters).
  - Set `core_nonce`=start.
  - If count=0: pulse `done` and stay in IDLE. Otherwise go to LOAD.
- LOAD: `core_rst`=1 for exactly LOAD_CYCLES cycles. The core samples `core_nonce` in the last LOAD cycle; that sample counts as issue #1. Then go to RUN.
- RUN: `core_rst`=0.
  - Every NONCE_PERIOD cycles after LOAD exits, the core takes a sample; on each sample `issued`++.
  - `core_nonce` advances by 1 (mod 2^32, 0xFFFFFFFF→0) in the cycle after each sample.
  - When `issued` reaches count, go to DRAIN. `core_nonce` then freezes; later core samples are not counted.
- Result handling (RUN and DRAIN), for each `core_hash_ready` with `returned` < count:
  - result nonce = start + `returned` (mod 2^32).
  - `returned`++, `hashes_done`++.
  - If `core_hash <= target`, push {nonce, hash}.
  - Results with `returned` ≥ count are ignored.
- DRAIN: leave when `returned` = count. Pulse `done`, drive `core_rst`=1, go to IDLE.
- abort (LOAD/RUN/DRAIN): next state is IDLE, `core_rst`=1 from the next cycle, in-flight results are discarded, no `done`. FIFO contents are kept. abort in IDLE is ignored.
- FIFO:
  - Push when full: the hit is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed, because the pop frees the slot first.
  - Push and pop in the same cycle while empty: the entry is written; `found_valid` rises the next cycle (no bypass).
- A work offer during busy is not accepted (`work_ready`=0). The offer is held by the source.

## Timing
- Reset values: `work_ready`=0 during reset then 1 the cycle after release; `core_rst`=1; `core_state`/`core_data`/`core_nonce`=0; `found_valid`=0; `found_nonce`/`found_hash`=0; `busy`=0; `done`=0; `overflow`=0; `hashes_done`=0. FIFO is empty and state is IDLE.
- Accept edge → LOAD begins next cycle; `busy`=1 from that cycle.
- Hit result → `found_valid` asserts at +1 cycle (registered FIFO output).
- Final `core_hash_ready` → `done` pulse at +1 cycle; `core_rst`=1 and `busy`=0 in that same cycle; `work_ready`=1 the cycle after.
- Reset asserted mid-unit: everything returns to reset values on that edge; FIFO is flushed.

## Test plan
- Core model with latency 60 and NONCE_PERIOD 14. start=0x00000010, count=4, target=0xFFFFFFFF → 4 hits with nonces 0x10..0x13 in order; `done` 1 cycle after the 4th result; `hashes_done`=4.
- Wrap-around: start=0xFFFFFFFE, count=3, model hash=0 → hits with nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Target boundary: target=0x00001000, model hashes 0x00001000, 0x00001001 → exactly 1 hit (the first).
- Overflow: FOUND_DEPTH=4, `found_ready`=0, 6 hits → 4 entries queued and `overflow`=1. The next accept clears `overflow` and `hashes_done`.
- Simultaneous push and pop while full: `found_ready`=1 held → no drop, `overflow` stays 0.
- Abort mid-RUN after 2 results → `core_rst`=1 next cycle, no `done`; late results ignored; the next unit with count=0 pulses `done` from IDLE without entering LOAD.

Source files
------------

// File: rtl/blake_nonce_sched.sv
// blake_nonce_sched
// Work scheduler for one pipelined BLAKE-256 core. It takes a work unit,
// loads it into the core, paces nonces at a fixed cadence and pairs the
// in-order result stream with nonces. Results at or below the target are
// queued in a small found FIFO for the host side.
module blake_nonce_sched #(
    parameter int NONCE_PERIOD = 14,
    parameter int LOAD_CYCLES  = 2,
    parameter int FOUND_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_state,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_start,
    input  logic [31:0]  work_nonce_count,
    input  logic [31:0]  work_target,
    input  logic         abort,
    output logic         core_rst,
    output logic [255:0] core_state,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    input  logic         core_hash_ready,
    input  logic [31:0]  core_hash,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [31:0]  found_hash,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [31:0]  hashes_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int PW = $clog2(NONCE_PERIOD + 1);
    localparam int AW = $clog2(FOUND_DEPTH);
    localparam int FW = AW + 1;

    localparam logic [LW-1:0] LOAD_LAST    = LW'(LOAD_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(NONCE_PERIOD);
    localparam logic [PW-1:0] PERIOD_FIRST = PW'(1);
    localparam logic [FW-1:0] FIFO_FULL    = FW'(FOUND_DEPTH);

    // Control and work registers
    logic [1:0]    r_state;
    logic          r_work_ready;
    logic [255:0]  r_core_state;
    logic [95:0]   r_core_data;
    logic [31:0]   r_core_nonce;
    logic [31:0]   r_start;
    logic [31:0]   r_count;
    logic [31:0]   r_target;
    logic [32:0]   r_issued;
    logic [32:0]   r_returned;
    logic [LW-1:0] r_load_cnt;
    logic [PW-1:0] r_period_cnt;
    logic          r_done;
    logic          r_overflow;

    // Found FIFO storage and pointers
    logic [31:0]   r_mem_nonce [FOUND_DEPTH];
    logic [31:0]   r_mem_hash  [FOUND_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;

    logic          w_accept;
    logic          w_active;
    logic          w_sample;
    logic          w_last_issue;
    logic          w_res_valid;
    logic          w_last_result;
    logic          w_hit;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [32:0]   w_count33;
    logic [31:0]   w_res_nonce;

    assign w_count33    = {1'b0, r_count};
    assign w_accept     = work_valid & r_work_ready;
    assign w_active     = (r_state == ST_RUN) | (r_state == ST_DRAIN);

    // The core takes a nonce on the last LOAD cycle and then once per period in RUN.
    assign w_sample     = ((r_state == ST_LOAD) & (r_load_cnt == LOAD_LAST)) |
                          ((r_state == ST_RUN) & (r_period_cnt == PERIOD_LAST));
    assign w_last_issue = ((r_issued + 33'd1) == w_count33);

    // Results beyond the unit's count (extra core samples) are not ours; abort wins over a result.
    assign w_res_valid   = core_hash_ready & w_active & ~abort & (r_returned < w_count33);
    assign w_last_result = w_res_valid & ((r_returned + 33'd1) == w_count33);
    assign w_res_nonce   = r_start + r_returned[31:0];
    assign w_hit         = w_res_valid & (core_hash <= r_target);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign found_valid = (r_fill != '0);
    assign w_full      = (r_fill == FIFO_FULL);
    assign w_pop       = found_valid & found_ready;
    assign w_push      = w_hit & (~w_full | w_pop);
    assign w_drop      = w_hit & w_full & ~w_pop;

    assign found_nonce = found_valid ? r_mem_nonce[r_rd_ptr] : 32'd0;
    assign found_hash  = found_valid ? r_mem_hash[r_rd_ptr]  : 32'd0;

    assign work_ready  = r_work_ready;
    assign core_rst    = (r_state == ST_IDLE) | (r_state == ST_LOAD);
    assign core_state  = r_core_state;
    assign core_data   = r_core_data;
    assign core_nonce  = r_core_nonce;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign hashes_done = r_returned[31:0];

    // Scheduler FSM: accept, load, nonce pacing, result counting and completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_work_ready <= 1'b0;
            r_core_state <= '0;
            r_core_data  <= '0;
            r_core_nonce <= '0;
            r_start      <= '0;
            r_count      <= '0;
            r_target     <= '0;
            r_issued     <= '0;
            r_returned   <= '0;
            r_load_cnt   <= '0;
            r_period_cnt <= PERIOD_FIRST;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_res_valid) begin
                r_returned <= r_returned + 33'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // Ready rises one cycle after arriving in IDLE.
                    r_work_ready <= 1'b1;
                    if (w_accept) begin
                        r_core_state <= work_state;
                        r_core_data  <= work_data;
                        r_core_nonce <= work_nonce_start;
                        r_start      <= work_nonce_start;
                        r_count      <= work_nonce_count;
                        r_target     <= work_target;
                        r_issued     <= '0;
                        r_returned   <= '0;
                        r_overflow   <= 1'b0;
                        r_load_cnt   <= '0;
                        if (work_nonce_count == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_work_ready <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_work_ready <= 1'b0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_sample) begin
                        r_issued     <= 33'd1;
                        r_period_cnt <= PERIOD_FIRST;
                        if (w_last_issue) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state      <= ST_RUN;
                            r_core_nonce <= r_core_nonce + 32'd1;
                        end
                    end else begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_work_ready <= 1'b0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_sample) begin
                        r_issued     <= r_issued + 33'd1;
                        r_period_cnt <= PERIOD_FIRST;
                        if (w_last_issue) begin
                            // Nonce stays put once the range is fully issued.
                            r_state <= ST_DRAIN;
                        end else begin
                            r_core_nonce <= r_core_nonce + 32'd1;
                        end
                    end else begin
                        r_period_cnt <= r_period_cnt + 1'b1;
                    end
                end
                default: begin
                    r_work_ready <= 1'b0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_last_result) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Found FIFO pointer and fill bookkeeping; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Found FIFO storage write; contents are only visible while the entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_nonce[r_wr_ptr] <= w_res_nonce;
            r_mem_hash[r_wr_ptr]  <= core_hash;
        end
    end

endmodule

// File: tb/tb_blake_nonce_sched.sv
// tb_blake_nonce_sched
// Directed bench for blake_nonce_sched with a behavioural core model
// (latency 60, one sample per 14 cycles while out of reset/load).
module tb_blake_nonce_sched;

    localparam int NP  = 14;
    localparam int LAT = 60;

    logic         clk = 1'b0;
    logic         rst;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_state;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_count;
    logic [31:0]  work_target;
    logic         abort;
    logic         core_rst;
    logic [255:0] core_state;
    logic [95:0]  core_data;
    logic [31:0]  core_nonce;
    logic         core_hash_ready;
    logic [31:0]  core_hash;
    logic         found_valid;
    logic         found_ready;
    logic [31:0]  found_nonce;
    logic [31:0]  found_hash;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [31:0]  hashes_done;

    blake_nonce_sched #(.NONCE_PERIOD(14), .LOAD_CYCLES(2), .FOUND_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_state(work_state), .work_data(work_data),
        .work_nonce_start(work_nonce_start), .work_nonce_count(work_nonce_count),
        .work_target(work_target), .abort(abort),
        .core_rst(core_rst), .core_state(core_state), .core_data(core_data),
        .core_nonce(core_nonce), .core_hash_ready(core_hash_ready), .core_hash(core_hash),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .busy(busy), .done(done), .overflow(overflow), .hashes_done(hashes_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model state
    logic [31:0] m_start = 0, m_base = 0, m_step = 0;
    logic [31:0] q_nonce[$];
    int          q_due[$];
    int          q_idx[$];
    logic        m_armed = 1'b0;
    logic [31:0] m_first = 0;
    int          m_phase = 0;
    int          m_next_idx = 0;
    logic [31:0] t_n;
    int          t_ix, t_due;
    int          last_rdy_cyc = 0;
    logic        pp_mode = 1'b0;
    logic        fv_arm = 1'b0;
    logic        fv_pending = 1'b0;
    logic [255:0] exp_state;
    logic [95:0]  exp_data;

    // Core model: samples nonces, returns hashes LAT cycles later in order.
    always @(negedge clk) begin
        if (fv_pending) begin
            chk("found_valid one cycle after hit", found_valid, 1'b1);
            fv_pending = 1'b0;
        end
        core_hash_ready = 1'b0;
        core_hash = 32'd0;
        if (pp_mode) found_ready = 1'b0;
        if (q_due.size() > 0) begin
            if (q_due[0] <= cyc) begin
                t_n = q_nonce.pop_front();
                t_ix = q_idx.pop_front();
                t_due = q_due.pop_front();
                core_hash_ready = 1'b1;
                core_hash = m_base + m_step * (t_n - m_start);
                if (pp_mode && busy && t_ix >= 4) found_ready = 1'b1;
                if (busy) last_rdy_cyc = cyc;
            end
        end
        if (fv_arm && core_hash_ready && busy) begin
            chk("found_valid low in hit cycle", found_valid, 1'b0);
            fv_pending = 1'b1;
            fv_arm = 1'b0;
        end
        if (core_rst) begin
            m_armed = 1'b1;
            m_first = core_nonce;
            m_phase = 0;
        end else if (m_armed) begin
            q_nonce.push_back(m_first);
            q_due.push_back(cyc - 1 + LAT);
            q_idx.push_back(0);
            m_armed = 1'b0;
            m_phase = 1;
            m_next_idx = 1;
        end else begin
            m_phase++;
            if (m_phase == NP) begin
                q_nonce.push_back(core_nonce);
                q_due.push_back(cyc + LAT);
                q_idx.push_back(m_next_idx);
                m_next_idx++;
                m_phase = 0;
            end
        end
    end

    task automatic start_unit(input logic [31:0] s, input logic [31:0] c, input logic [31:0] t,
                              input logic [31:0] b, input logic [31:0] st);
        int w = 0;
        m_start = s; m_base = b; m_step = st;
        exp_state = {8{s ^ 32'hA5A5_5A5A}};
        exp_data  = {s, c, t};
        work_state = exp_state;
        work_data = exp_data;
        work_nonce_start = s;
        work_nonce_count = c;
        work_target = t;
        work_valid = 1'b1;
        while (work_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        chk("work_ready before accept", work_ready, 1'b1);
        @(negedge clk);
        work_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (done !== 1'b1 && w < 1500) begin @(negedge clk); w++; end
        chk({tag, " done pulse"}, done, 1'b1);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] en, input logic [31:0] eh);
        int w = 0;
        while (found_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk({tag, " valid"}, found_valid, 1'b1);
        chk({tag, " nonce"}, found_nonce, en);
        chk({tag, " hash"}, found_hash, eh);
        found_ready = 1'b1;
        @(negedge clk);
        found_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout cycles=%0d", cyc);
        $fatal(1, "simulation timeout");
    end

    // Directed sequence
    initial begin
        int seen;
        int w;
        rst = 1'b0; work_valid = 1'b0; work_state = '0; work_data = '0;
        work_nonce_start = '0; work_nonce_count = '0; work_target = '0;
        abort = 1'b0; core_hash_ready = 1'b0; core_hash = '0; found_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst work_ready", work_ready, 1'b0);
        chk("rst core_rst", core_rst, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst found_valid", found_valid, 1'b0);
        chk("rst found_nonce", found_nonce, 32'd0);
        chk("rst core_nonce", core_nonce, 32'd0);
        chk("rst hashes_done", hashes_done, 32'd0);
        chk("rst overflow", overflow, 1'b0);
        chk("rst done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("work_ready after release", work_ready, 1'b1);

        // Basic unit: 4 hits 0x10..0x13
        fv_arm = 1'b1;
        start_unit(32'h10, 32'd4, 32'hFFFF_FFFF, 32'h100, 32'd1);
        chk("t1 busy in LOAD", busy, 1'b1);
        chk("t1 core_rst in LOAD", core_rst, 1'b1);
        chk("t1 work_ready in LOAD", work_ready, 1'b0);
        chk("t1 core_nonce", core_nonce, 32'h10);
        chk("t1 core_state", core_state, exp_state);
        chk("t1 core_data", core_data, exp_data);
        wait_done("t1");
        chk("t1 done latency", cyc - last_rdy_cyc, 1);
        chk("t1 hashes_done", hashes_done, 32'd4);
        chk("t1 busy at done", busy, 1'b0);
        chk("t1 core_rst at done", core_rst, 1'b1);
        chk("t1 work_ready at done", work_ready, 1'b0);
        @(negedge clk);
        chk("t1 work_ready after done", work_ready, 1'b1);
        chk("t1 done one cycle", done, 1'b0);
        repeat (90) @(negedge clk);
        chk("t1 overflow", overflow, 1'b0);
        chk("t1 hashes_done after extras", hashes_done, 32'd4);
        pop_check("t1 e0", 32'h10, 32'h100);
        pop_check("t1 e1", 32'h11, 32'h101);
        pop_check("t1 e2", 32'h12, 32'h102);
        pop_check("t1 e3", 32'h13, 32'h103);
        chk("t1 fifo empty", found_valid, 1'b0);

        // Nonce wrap-around
        start_unit(32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'd0);
        wait_done("t2");
        chk("t2 hashes_done", hashes_done, 32'd3);
        repeat (90) @(negedge clk);
        pop_check("t2 e0", 32'hFFFF_FFFE, 32'd0);
        pop_check("t2 e1", 32'hFFFF_FFFF, 32'd0);
        pop_check("t2 e2", 32'h0000_0000, 32'd0);
        chk("t2 fifo empty", found_valid, 1'b0);

        // Target boundary: 0x1000 hits, 0x1001 does not
        start_unit(32'h100, 32'd2, 32'h0000_1000, 32'h1000, 32'd1);
        wait_done("t3");
        chk("t3 hashes_done", hashes_done, 32'd2);
        repeat (90) @(negedge clk);
        pop_check("t3 e0", 32'h100, 32'h1000);
        chk("t3 single hit", found_valid, 1'b0);

        // Overflow with found_ready held low
        start_unit(32'h200, 32'd6, 32'hFFFF_FFFF, 32'h2000, 32'd1);
        wait_done("t4");
        repeat (90) @(negedge clk);
        chk("t4 overflow", overflow, 1'b1);
        chk("t4 hashes_done", hashes_done, 32'd6);
        pop_check("t4 e0", 32'h200, 32'h2000);
        pop_check("t4 e1", 32'h201, 32'h2001);
        pop_check("t4 e2", 32'h202, 32'h2002);
        pop_check("t4 e3", 32'h203, 32'h2003);
        chk("t4 fifo empty", found_valid, 1'b0);

        // Push and pop together while full
        pp_mode = 1'b1;
        start_unit(32'h300, 32'd6, 32'hFFFF_FFFF, 32'h3000, 32'd1);
        chk("t5 overflow cleared on accept", overflow, 1'b0);
        chk("t5 hashes_done cleared on accept", hashes_done, 32'd0);
        wait_done("t5");
        pp_mode = 1'b0;
        found_ready = 1'b0;
        repeat (90) @(negedge clk);
        chk("t5 no overflow", overflow, 1'b0);
        chk("t5 hashes_done", hashes_done, 32'd6);
        pop_check("t5 e0", 32'h302, 32'h3002);
        pop_check("t5 e1", 32'h303, 32'h3003);
        pop_check("t5 e2", 32'h304, 32'h3004);
        pop_check("t5 e3", 32'h305, 32'h3005);
        chk("t5 fifo empty", found_valid, 1'b0);

        // Abort mid-RUN after two results
        start_unit(32'h400, 32'd10, 32'hFFFF_FFFF, 32'h4000, 32'd1);
        w = 0;
        while (hashes_done !== 32'd2 && w < 500) begin @(negedge clk); w++; end
        chk("t6 two results", hashes_done, 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6 core_rst after abort", core_rst, 1'b1);
        chk("t6 busy after abort", busy, 1'b0);
        seen = 0;
        repeat (100) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("t6 no done after abort", seen, 0);
        chk("t6 late results ignored", hashes_done, 32'd2);
        pop_check("t6 e0", 32'h400, 32'h4000);
        pop_check("t6 e1", 32'h401, 32'h4001);
        chk("t6 fifo empty", found_valid, 1'b0);

        // Empty range completes from IDLE
        start_unit(32'h500, 32'd0, 32'hFFFF_FFFF, 32'h5000, 32'd1);
        chk("t6b done from idle", done, 1'b1);
        chk("t6b no LOAD", busy, 1'b0);
        chk("t6b core_rst", core_rst, 1'b1);
        chk("t6b hashes_done cleared", hashes_done, 32'd0);
        @(negedge clk);
        chk("t6b done one cycle", done, 1'b0);
        chk("t6b still idle", busy, 1'b0);

        // Reset mid-unit flushes everything
        start_unit(32'h600, 32'd4, 32'hFFFF_FFFF, 32'h6000, 32'd1);
        w = 0;
        while (found_valid !== 1'b1 && w < 500) begin @(negedge clk); w++; end
        chk("t7 hit queued", found_valid, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("t7 fifo flushed", found_valid, 1'b0);
        chk("t7 busy", busy, 1'b0);
        chk("t7 hashes_done", hashes_done, 32'd0);
        chk("t7 core_nonce", core_nonce, 32'd0);
        chk("t7 work_ready", work_ready, 1'b0);
        chk("t7 core_rst", core_rst, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t7 work_ready after release", work_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
